// File: rtl/fios_dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fios_dsp_pkg
// Description : Shared widths, DSP48E2 OPMODE encodings and pipeline tag type
//               for the FIOS DSP sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fios_dsp_pkg;

    localparam int c_WORD_W = 17;
    localparam int c_P_W    = 34;

    // W=C, Z=0, X/Y=M
    localparam logic [8:0] c_OPMODE_FIRST = 9'h185;
    // W=C, Z=P>>17, X/Y=M
    localparam logic [8:0] c_OPMODE_NEXT  = 9'h1E5;
    localparam logic [8:0] c_OPMODE_HOLD  = 9'h020;
    localparam logic [8:0] c_OPMODE_CLR   = 9'h000;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    function automatic logic [8:0] opmode_for(input tag_t tag);
        if (!tag.valid) begin
            return c_OPMODE_HOLD;
        end
        return tag.first ? c_OPMODE_FIRST : c_OPMODE_NEXT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fios_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fios_result_fifo
// Description : Synchronous FIFO with arbitrary depth and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module fios_result_fifo #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 35
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_push_data,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_head,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [0:DEPTH-1];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fios_dsp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fios_dsp_sequencer
// Description : Drives one DSP48E2 MAC slice of a FIOS PE with aligned operands
//               and OPMODE, and returns row result words on a credited stream.
// Revision    : 1.0 - initial release
// ============================================================================
module fios_dsp_sequencer
    import fios_dsp_pkg::*;
#(
    parameter int S     = 8,
    parameter int ABREG = 1,
    parameter int MREG  = 1
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [c_WORD_W-1:0] a_i,
    input  logic [c_WORD_W-1:0] b_i,
    input  logic [c_WORD_W-1:0] t_i,
    output logic [8:0]          OPMODE_o,
    output logic                CREG_en_o,
    output logic [c_WORD_W-1:0] A_o,
    output logic [c_WORD_W-1:0] B_o,
    output logic [c_P_W-1:0]    C_o,
    input  logic [c_P_W-1:0]    P_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [c_WORD_W-1:0] res_word_o,
    output logic                res_last_o,
    output logic [c_WORD_W-1:0] res_carry_o
);

    localparam int L         = 1 + ABREG + MREG;
    localparam int DEPTH     = L + 2;
    localparam int c_C_STAGE = ABREG + MREG;
    localparam int c_CNT_W   = $clog2(S);
    localparam int c_FIFO_W  = 2 * c_WORD_W + 1;
    localparam int c_FCNT_W  = $clog2(DEPTH + 1);
    localparam int c_OCC_W   = $clog2(2 * DEPTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ROW  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic                 w_accept;
    tag_t                 w_tag0;
    tag_t                 r_tag_pipe [1:L+1];
    tag_t                 w_tag_c;
    logic [c_WORD_W-1:0]  w_t_c;
    logic [c_OCC_W-1:0]   w_inflight;
    logic [c_FCNT_W-1:0]  w_fifo_count;
    logic [c_FIFO_W-1:0]  w_head;
    logic                 w_push;
    logic                 w_pop;

    assign w_accept = in_valid_i && in_ready_o;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_tag0      = '0;
        if (w_accept) begin
            w_tag0.valid = 1'b1;
            w_tag0.first = (r_state == ST_IDLE);
            w_tag0.last  = (r_count == c_CNT_W'(S - 1));
            if (w_tag0.last) begin
                w_count_nxt = '0;
                w_state_nxt = ST_IDLE;
            end else begin
                w_count_nxt = r_count + 1'b1;
                w_state_nxt = ST_ROW;
            end
        end
    end

    // Tag stage i holds the word accepted i cycles earlier; stage L+1 meets P.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 1; i <= L + 1; i++) begin
                r_tag_pipe[i] <= '0;
            end
        end else begin
            r_tag_pipe[1] <= w_tag0;
            for (int i = 2; i <= L + 1; i++) begin
                r_tag_pipe[i] <= r_tag_pipe[i-1];
            end
        end
    end

    generate
        if (c_C_STAGE == 1) begin : g_c_from_accept
            assign w_tag_c = w_tag0;
            assign w_t_c   = t_i;
        end else begin : g_c_from_pipe
            logic [c_WORD_W-1:0] r_t_pipe [1:c_C_STAGE-1];
            always_ff @(posedge clock_i) begin
                r_t_pipe[1] <= t_i;
                for (int i = 2; i < c_C_STAGE; i++) begin
                    r_t_pipe[i] <= r_t_pipe[i-1];
                end
            end
            assign w_tag_c = r_tag_pipe[c_C_STAGE-1];
            assign w_t_c   = r_t_pipe[c_C_STAGE-1];
        end
    endgenerate

    // OPMODE and C are registered once more inside the slice, landing with M.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            A_o       <= '0;
            B_o       <= '0;
            C_o       <= '0;
            OPMODE_o  <= c_OPMODE_CLR;
            CREG_en_o <= 1'b0;
        end else begin
            if (w_accept) begin
                A_o <= a_i;
                B_o <= b_i;
            end
            C_o       <= {{(c_P_W - c_WORD_W){1'b0}}, w_t_c};
            OPMODE_o  <= opmode_for(w_tag_c);
            CREG_en_o <= w_tag_c.valid;
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int i = 1; i <= L + 1; i++) begin
            w_inflight = w_inflight + c_OCC_W'(r_tag_pipe[i].valid);
        end
    end

    // Credits cover every word already in the slice, since it cannot stall.
    assign in_ready_o = !reset_i &&
                        ((c_OCC_W'(w_fifo_count) + w_inflight) < c_OCC_W'(DEPTH));

    assign w_push = r_tag_pipe[L+1].valid;
    assign w_pop  = res_valid_o && res_ready_i;

    fios_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_FIFO_W)
    ) u_fifo (
        .clk         (clock_i),
        .rst         (reset_i),
        .i_push      (w_push),
        .i_push_data ({P_i[c_WORD_W-1:0], r_tag_pipe[L+1].last, P_i[c_P_W-1:c_WORD_W]}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count)
    );

    assign res_valid_o = (w_fifo_count != '0);
    assign res_word_o  = w_head[c_FIFO_W-1 -: c_WORD_W];
    assign res_last_o  = res_valid_o && w_head[c_WORD_W];
    assign res_carry_o = w_head[c_WORD_W-1:0];

endmodule
`default_nettype wire
